zb_param_fifo: RTL and testbench
================================

ZB_PARAM_FIFO -- requirements
Module: zb_param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 4, data word width (1..32).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, 2..256).
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost-full level.
REQ-004 SHALL have parameter AE_THRESH, default 2, almost-empty level.
REQ-005 SHALL have port inClock  in  1  sole clock, rising edge.
REQ-006 SHALL have port inReset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port inWriteEnable  in  1  write request.
REQ-008 SHALL have port inData  in  DATA_W  write data.
REQ-009 SHALL have port inReadEnable  in  1  read request.
REQ-010 SHALL have port inClearFlags  in  1  clear sticky error flags.
REQ-011 SHALL have port outData  out  DATA_W  read data.
REQ-012 SHALL have port outValid  out  1  outData holds a popped or head word.
REQ-013 SHALL have port outFull / outEmpty  out  1 each  occupancy limits.
REQ-014 SHALL have port outAlmostFull / outAlmostEmpty  out  1 each  threshold flags.
REQ-015 SHALL have port outCount  out  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port outOverflow / outUnderflow  out  1 each  sticky error flags.

Function
REQ-017 Read accepted iff inReadEnable and count>0; write accepted iff inWriteEnable and (count<DEPTH or read accepted same cycle).
REQ-018 Accepted write stores inData at write pointer; pointers wrap DEPTH-1 -> 0.
REQ-019 Count +1 on write only, -1 on read only, unchanged on both or neither; outCount registered, reflects state after the edge.
REQ-020 Simultaneous read+write at count=0: read rejected, write accepted, count becomes 1.
REQ-021 Simultaneous read+write at count=DEPTH: both accepted, count stays DEPTH.
REQ-022 outFull = (count==DEPTH); outEmpty = (count==0); outAlmostFull = (count>=AF_THRESH); outAlmostEmpty = (count<=AE_THRESH); all derived from registered count.
REQ-023 outOverflow sets when write requested but rejected; outUnderflow sets when read requested at count=0.
REQ-024 Flags stay set until inClearFlags; a new error in the same cycle as inClearFlags wins (flag remains 1).
REQ-025 Standard mode: outData updates one cycle after accepted read, outValid pulses high that cycle; otherwise outData holds last value, outValid 0.
REQ-026 Data order strictly FIFO; no word lost or duplicated across wrap-around.

Reset
REQ-027 inReset asserted SHALL immediately clear pointers, count, outData, outValid, outFull, outAlmostFull, outOverflow, outUnderflow to 0 and set outEmpty, outAlmostEmpty to 1.
REQ-028 Reset mid-operation SHALL discard all stored words; storage array itself needs no reset.
REQ-029 First accepted write SHALL be possible on the first rising edge after inReset deasserts.

Configuration
REQ-030 Macro ZB_FIFO_FWFT_EN defined: first-word-fall-through; outData shows head word whenever count>0, outValid = !outEmpty, accepted read advances to next word same edge; write into empty FIFO visible one cycle later.
REQ-031 Macro ZB_FIFO_FWFT_EN undefined: standard registered-read mode of REQ-025; all other behaviour identical.

Structure
REQ-032 Package zb_fifo_pkg SHALL hold default DATA_W/DEPTH constants, count-width function and error-flag bit-index constants.
REQ-033 Storage SHALL be sub-module zb_fifo_ram (1 write port, 1 registered read port, DATA_W x DEPTH); control, count and flags in zb_param_fifo.
REQ-034 Parameter legality (DEPTH power of two, AE_THRESH<AF_THRESH<=DEPTH) SHALL be checked at elaboration.

Verification (DATA_W=4, DEPTH=16)
REQ-035 Reset, then write 1,4,9 and read 3 -> outData 1,4,9 in order; outCount 3->0; outEmpty=1.
REQ-036 Write 16 words 0..15 -> outFull=1 at count 16, outAlmostFull=1 from count 14; 17th write -> outOverflow=1, count stays 16.
REQ-037 Full FIFO, simultaneous read+write of 0xD -> read returns 0, count stays 16, no overflow; drain returns 1..15 then 0xD.
REQ-038 Read at empty -> outUnderflow=1, outValid=0; assert inClearFlags with simultaneous empty read -> outUnderflow stays 1; clear alone -> 0.
REQ-039 20 writes / 20 reads interleaved across wrap -> sequence 0..19 mod 16 preserved; inReset pulse at count 7 -> count 0, outEmpty=1 asynchronously.
REQ-040 ZB_FIFO_FWFT_EN defined: write 0x6 to empty -> outValid=1 and outData=0x6 next cycle without read; read -> outValid=0.

Source files
------------

// File: rtl/zb_fifo_pkg.sv
// Shared constants and helpers for the zb_param_fifo block.
// Default word width/depth, count-width function and sticky-error bit indices.
package zb_fifo_pkg;

    localparam int unsigned ZbDefDataW = 4;
    localparam int unsigned ZbDefDepth = 16;

    localparam int unsigned ErrOverflow  = 0;
    localparam int unsigned ErrUnderflow = 1;
    localparam int unsigned NumErr       = 2;

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int unsigned zb_count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/zb_fifo_ram.sv
// DATA_W x DEPTH storage: one write port, one registered read port.
// WRITE_FIRST forwards same-address write data to the read register.
module zb_fifo_ram #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned DEPTH       = 16,
    parameter bit          WRITE_FIRST = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; the array contents are don't-care.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            if (WRITE_FIRST && i_we && (i_waddr == i_raddr)) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/zb_param_fifo.sv
// Parameterised synchronous FIFO with threshold flags and sticky error flags.
// Define ZB_FIFO_FWFT_EN for first-word-fall-through; default is registered read.
module zb_param_fifo
    import zb_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = ZbDefDataW,
    parameter int unsigned DEPTH     = ZbDefDepth,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                     inClock,
    input  logic                     inReset,
    input  logic                     inWriteEnable,
    input  logic [DATA_W-1:0]        inData,
    input  logic                     inReadEnable,
    input  logic                     inClearFlags,
    output logic [DATA_W-1:0]        outData,
    output logic                     outValid,
    output logic                     outFull,
    output logic                     outEmpty,
    output logic                     outAlmostFull,
    output logic                     outAlmostEmpty,
    output logic [$clog2(DEPTH):0]   outCount,
    output logic                     outOverflow,
    output logic                     outUnderflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = zb_count_w(DEPTH);

    localparam logic [CW-1:0] FullLvl = CW'(DEPTH);
    localparam logic [CW-1:0] AfLvl   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeLvl   = CW'(AE_THRESH);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("zb_param_fifo: DEPTH must be a power of two in 2..256");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("zb_param_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
        $error("zb_param_fifo: DATA_W must be in 1..32");
    end

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [NumErr-1:0] r_err;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [AW-1:0]     w_wr_ptr_d;
    logic [AW-1:0]     w_rd_ptr_d;
    logic [CW-1:0]     w_count_d;
    logic [NumErr-1:0] w_err_set;
    logic [NumErr-1:0] w_err_d;
    logic              w_ram_re;
    logic [AW-1:0]     w_ram_raddr;
    logic [DATA_W-1:0] w_ram_rdata;

    always_comb begin
        w_rd_acc = inReadEnable && (r_count != '0);
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        w_wr_acc = inWriteEnable && ((r_count != FullLvl) || w_rd_acc);

        w_wr_ptr_d = w_wr_acc ? r_wr_ptr + 1'b1 : r_wr_ptr;
        w_rd_ptr_d = w_rd_acc ? r_rd_ptr + 1'b1 : r_rd_ptr;

        w_count_d = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase

        w_err_set               = '0;
        w_err_set[ErrOverflow]  = inWriteEnable && !w_wr_acc;
        w_err_set[ErrUnderflow] = inReadEnable && (r_count == '0);
        // New errors win over a simultaneous clear.
        w_err_d = (inClearFlags ? '0 : r_err) | w_err_set;
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_count  <= w_count_d;
            r_err    <= w_err_d;
        end
    end

`ifdef ZB_FIFO_FWFT_EN
    localparam bit RamWriteFirst = 1'b1;

    // Continuously prefetch the post-edge head so it is on outData after every edge.
    assign w_ram_re    = 1'b1;
    assign w_ram_raddr = w_rd_ptr_d;
    assign outValid    = !outEmpty;
`else
    localparam bit RamWriteFirst = 1'b0;

    logic r_valid;

    assign w_ram_re    = w_rd_acc;
    assign w_ram_raddr = r_rd_ptr;

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
        end
    end

    assign outValid = r_valid;
`endif

    zb_fifo_ram #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WRITE_FIRST (RamWriteFirst)
    ) u_ram (
        .i_clk   (inClock),
        .i_rst   (inReset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (inData),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign outData        = w_ram_rdata;
    assign outCount       = r_count;
    assign outFull        = (r_count == FullLvl);
    assign outEmpty       = (r_count == '0);
    assign outAlmostFull  = (r_count >= AfLvl);
    assign outAlmostEmpty = (r_count <= AeLvl);
    assign outOverflow    = r_err[ErrOverflow];
    assign outUnderflow   = r_err[ErrUnderflow];

endmodule

// File: tb/tb_zb_param_fifo.sv
// Self-checking bench for zb_param_fifo (DATA_W=4, DEPTH=16) against a queue model.
// Handles both the default build and ZB_FIFO_FWFT_EN.
module tb_zb_param_fifo;

    localparam int unsigned DW = 4;
    localparam int unsigned DP = 16;
    localparam int unsigned AF = DP - 2;
    localparam int unsigned AE = 2;

    logic          inClock;
    logic          inReset;
    logic          inWriteEnable;
    logic [DW-1:0] inData;
    logic          inReadEnable;
    logic          inClearFlags;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          outFull;
    logic          outEmpty;
    logic          outAlmostFull;
    logic          outAlmostEmpty;
    logic [4:0]    outCount;
    logic          outOverflow;
    logic          outUnderflow;

    zb_param_fifo #(
        .DATA_W (DW),
        .DEPTH  (DP)
    ) dut (
        .inClock        (inClock),
        .inReset        (inReset),
        .inWriteEnable  (inWriteEnable),
        .inData         (inData),
        .inReadEnable   (inReadEnable),
        .inClearFlags   (inClearFlags),
        .outData        (outData),
        .outValid       (outValid),
        .outFull        (outFull),
        .outEmpty       (outEmpty),
        .outAlmostFull  (outAlmostFull),
        .outAlmostEmpty (outAlmostEmpty),
        .outCount       (outCount),
        .outOverflow    (outOverflow),
        .outUnderflow   (outUnderflow)
    );

    initial inClock = 1'b0;
    always #5 inClock = ~inClock;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_data;
    bit            m_valid;
    bit            m_ovf;
    bit            m_unf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, "_cnt"},   32'(outCount),       32'(n));
        check({tag, "_full"},  32'(outFull),        32'(n == DP));
        check({tag, "_empty"}, 32'(outEmpty),       32'(n == 0));
        check({tag, "_af"},    32'(outAlmostFull),  32'(n >= AF));
        check({tag, "_ae"},    32'(outAlmostEmpty), 32'(n <= AE));
        check({tag, "_ovf"},   32'(outOverflow),    32'(m_ovf));
        check({tag, "_unf"},   32'(outUnderflow),   32'(m_unf));
`ifdef ZB_FIFO_FWFT_EN
        check({tag, "_vld"}, 32'(outValid), 32'(n > 0));
        if (n > 0) check({tag, "_dat"}, 32'(outData), 32'(q[0]));
`else
        check({tag, "_vld"}, 32'(outValid), 32'(m_valid));
        check({tag, "_dat"}, 32'(outData),  32'(m_data));
`endif
    endtask

    task automatic step(input bit we, input logic [DW-1:0] d, input bit re, input bit clr,
                        input string tag);
        int  n;
        bit  rd;
        bit  wr;
        inWriteEnable = we;
        inData        = d;
        inReadEnable  = re;
        inClearFlags  = clr;
        @(posedge inClock);
        n  = q.size();
        rd = re && (n > 0);
        wr = we && ((n < DP) || rd);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (we && !wr) m_ovf = 1'b1;
        if (re && n == 0) m_unf = 1'b1;
        m_valid = 1'b0;
        if (rd) begin
            m_data  = q.pop_front();
            m_valid = 1'b1;
        end
        if (wr) q.push_back(d);
        #1;
        check_all(tag);
        inWriteEnable = 1'b0;
        inReadEnable  = 1'b0;
        inClearFlags  = 1'b0;
    endtask

    // Asserted between edges so the checks show the reset acting asynchronously.
    task automatic do_reset(input string tag);
        inReset = 1'b1;
        #1;
        q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        check_all(tag);
        @(negedge inClock);
        inReset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp035 [3];
        exp035 = '{4'd1, 4'd4, 4'd9};
        inReset       = 1'b1;
        inWriteEnable = 1'b0;
        inData        = '0;
        inReadEnable  = 1'b0;
        inClearFlags  = 1'b0;
        m_data        = '0;

        do_reset("rst0");

        // Three writes then three reads
        step(1, 4'd1, 0, 0, "w1");
        step(1, 4'd4, 0, 0, "w4");
        step(1, 4'd9, 0, 0, "w9");
        for (int i = 0; i < 3; i++) begin
            step(0, 4'd0, 1, 0, "rd035");
`ifndef ZB_FIFO_FWFT_EN
            check("ord035", 32'(outData), 32'(exp035[i]));
`endif
        end
        check("empty035", 32'(outEmpty), 32'd1);

        // Fill to full and overflow
        for (int i = 0; i < 16; i++) step(1, DW'(i), 0, 0, "fill");
        check("full16", 32'(outFull), 32'd1);
        step(1, 4'hA, 0, 0, "w17");
        check("ovf17", 32'(outOverflow), 32'd1);
        check("cnt17", 32'(outCount), 32'd16);
        step(0, 4'd0, 0, 1, "clr_ovf");
        check("ovf_clr", 32'(outOverflow), 32'd0);

        // Simultaneous read/write while full
        step(1, 4'hD, 1, 0, "rw_full");
        check("rwf_cnt", 32'(outCount), 32'd16);
        check("rwf_ovf", 32'(outOverflow), 32'd0);
`ifndef ZB_FIFO_FWFT_EN
        check("rwf_dat", 32'(outData), 32'd0);
`endif
        for (int i = 0; i < 16; i++) step(0, 4'd0, 1, 0, "drain");
`ifndef ZB_FIFO_FWFT_EN
        check("drain_last", 32'(outData), 32'hD);
`endif

        // Underflow and clear priority
        step(0, 4'd0, 1, 0, "unf");
        check("unf_set", 32'(outUnderflow), 32'd1);
        check("unf_vld", 32'(outValid), 32'd0);
        step(0, 4'd0, 1, 1, "unf_clr_rd");
        check("unf_wins", 32'(outUnderflow), 32'd1);
        step(0, 4'd0, 0, 1, "unf_clr");
        check("unf_clear", 32'(outUnderflow), 32'd0);

        // Interleaved traffic across the wrap point
        for (int i = 0; i < 20; i++) begin
            step(1, DW'(i % 16), 0, 0, "il_w");
            step(0, 4'd0, 1, 0, "il_r");
        end

        // Reset mid-operation at count 7
        for (int i = 0; i < 7; i++) step(1, DW'(i + 3), 0, 0, "pre_rst");
        check("cnt7", 32'(outCount), 32'd7);
        do_reset("rst_mid");

        // First-cycle write after reset and simultaneous read+write at empty
        step(1, 4'h6, 1, 0, "rw_empty");
        check("rwe_cnt", 32'(outCount), 32'd1);
`ifdef ZB_FIFO_FWFT_EN
        check("fwft_vld", 32'(outValid), 32'd1);
        check("fwft_dat", 32'(outData), 32'h6);
        step(0, 4'd0, 1, 0, "fwft_rd");
        check("fwft_vld0", 32'(outValid), 32'd0);
`else
        step(0, 4'd0, 1, 0, "std_rd");
        check("std_dat6", 32'(outData), 32'h6);
`endif

        // Randomised traffic swinging between fill-biased and drain-biased phases
        for (int i = 0; i < 400; i++) begin
            bit fill;
            fill = ((i / 40) % 2) == 0;
            step($urandom_range(0, 3) != 0 ? fill : !fill,
                 DW'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0 ? !fill : fill,
                 $urandom_range(0, 15) == 0,
                 "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
